// File: rtl/orclr_irq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : orclr_irq_gen                                                 |
// | Description : Interrupt generator fed by a sticky OR-in / W1C status        |
// |               register. Registers the enabled pending vector and drives one |
// |               interrupt line, the lowest pending index, a pending flag and  |
// |               a saturating assertion count. A programmable hold-off after   |
// |               each clear limits the interrupt rate.                         |
// | Build macro : ORCLR_IRQ_PULSE_EN - irq_o is a one-cycle pulse on entry to   |
// |               ASSERT (edge-triggered controllers) instead of a level.       |
// | Ports       : clk_i      - clock, rising edge                               |
// |               rst_n_i    - synchronous active-low reset                     |
// |               status_i   - sticky status vector [N_SRC]                     |
// |               mask_i     - per-source enable, 1 = enabled [N_SRC]           |
// |               holdoff_i  - idle cycles after a clear [HOLD_W]               |
// |               irq_o      - interrupt request                                |
// |               irq_id_o   - lowest set index of the pending vector [ID_W]    |
// |               irq_pend_o - pending vector non-zero                          |
// |               irq_cnt_o  - saturating IDLE->ASSERT count [HOLD_W]           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module orclr_irq_gen #(
    parameter int N_SRC  = 32,
    parameter int ID_W   = 5,
    parameter int HOLD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_SRC-1:0]  status_i,
    input  logic [N_SRC-1:0]  mask_i,
    input  logic [HOLD_W-1:0] holdoff_i,
    output logic              irq_o,
    output logic [ID_W-1:0]   irq_id_o,
    output logic              irq_pend_o,
    output logic [HOLD_W-1:0] irq_cnt_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ASSERT  = 2'd1;
    localparam logic [1:0] c_HOLDOFF = 2'd2;

    logic [1:0]        r_state;
    logic [N_SRC-1:0]  r_pend;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_irq;
    logic [ID_W-1:0]   r_irq_id;
    logic [HOLD_W-1:0] r_irq_cnt;

    logic              w_pend_any;
    logic [ID_W-1:0]   w_pend_id;

    assign w_pend_any = |r_pend;

    // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        w_pend_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_pend_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= c_IDLE;
            r_pend     <= '0;
            r_hold_cnt <= '0;
            r_irq      <= 1'b0;
            r_irq_id   <= '0;
            r_irq_cnt  <= '0;
        end else begin
            r_pend   <= status_i & mask_i;
            r_irq_id <= w_pend_id;
            r_irq    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_pend_any) begin
                        r_state <= c_ASSERT;
                        r_irq   <= 1'b1;
                        if (r_irq_cnt != {HOLD_W{1'b1}}) begin
                            r_irq_cnt <= r_irq_cnt + 1'b1;
                        end
                    end
                end
                c_ASSERT: begin
                    if (w_pend_any) begin
`ifdef ORCLR_IRQ_PULSE_EN
                        r_irq <= 1'b0;
`else
                        r_irq <= 1'b1;
`endif
                    end else if (holdoff_i == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        // Interval is latched here; later holdoff_i changes
                        // do not stretch or shorten it.
                        r_hold_cnt <= holdoff_i;
                        r_state    <= c_HOLDOFF;
                    end
                end
                c_HOLDOFF: begin
                    // Sources firing now stay latched in the sticky status
                    // register and are picked up once back in IDLE.
                    r_hold_cnt <= r_hold_cnt - 1'b1;
                    if (r_hold_cnt <= {{(HOLD_W-1){1'b0}}, 1'b1}) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign irq_o      = r_irq;
    assign irq_id_o   = r_irq_id;
    assign irq_pend_o = w_pend_any;
    assign irq_cnt_o  = r_irq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_orclr_irq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_orclr_irq_gen                                              |
// | Description : Directed self-checking bench for orclr_irq_gen. A default     |
// |               instance covers the main behaviour; a HOLD_W=4 instance       |
// |               covers counter saturation.                                    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_orclr_irq_gen;

`ifdef ORCLR_IRQ_PULSE_EN
    localparam bit c_PULSE = 1'b1;
`else
    localparam bit c_PULSE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] status;
    logic [31:0] mask;
    logic [15:0] holdoff;
    logic        irq;
    logic [4:0]  irq_id;
    logic        irq_pend;
    logic [15:0] irq_cnt;

    logic [31:0] status2;
    logic        irq2;
    logic [4:0]  irq_id2;
    logic        irq_pend2;
    logic [3:0]  irq_cnt2;

    int total = 0;
    int bad   = 0;

    orclr_irq_gen #(.N_SRC(32), .ID_W(5), .HOLD_W(16)) u_dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .status_i   (status),
        .mask_i     (mask),
        .holdoff_i  (holdoff),
        .irq_o      (irq),
        .irq_id_o   (irq_id),
        .irq_pend_o (irq_pend),
        .irq_cnt_o  (irq_cnt)
    );

    orclr_irq_gen #(.N_SRC(32), .ID_W(5), .HOLD_W(4)) u_dut_sat (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .status_i   (status2),
        .mask_i     (32'hFFFF_FFFF),
        .holdoff_i  (4'd0),
        .irq_o      (irq2),
        .irq_id_o   (irq_id2),
        .irq_pend_o (irq_pend2),
        .irq_cnt_o  (irq_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        status  = 32'h0;
        status2 = 32'h0;
        mask    = 32'h0;
        holdoff = 16'h0;
        rst_n   = 1'b0;
        tick();
        tick();
        total++; if ({irq, irq_id, irq_pend, irq_cnt} !== 23'd0) begin
            bad++; $display("FAIL reset_outputs: got irq=%b id=%0d pend=%b cnt=%0d want all 0", irq, irq_id, irq_pend, irq_cnt);
        end
        total++; if ({irq2, irq_pend2, irq_cnt2} !== 6'd0) begin
            bad++; $display("FAIL reset_sat_outputs: got irq=%b pend=%b cnt=%0d want all 0", irq2, irq_pend2, irq_cnt2);
        end
        rst_n = 1'b1;
    endtask

    // status bit 4 appears in cycle 0: pending in cycle 1, irq in cycle 2.
    task automatic test_basic();
        mask   = 32'hFFFF_FFFF;
        status = 32'h0000_0010;
        tick();
        total++; if (irq_pend !== 1'b1 || irq !== 1'b0) begin
            bad++; $display("FAIL basic_cyc1: got pend=%b irq=%b want pend=1 irq=0", irq_pend, irq);
        end
        tick();
        total++; if (irq !== 1'b1 || irq_id !== 5'd4) begin
            bad++; $display("FAIL basic_cyc2: got irq=%b id=%0d want irq=1 id=4", irq, irq_id);
        end
        total++; if (irq_cnt !== 16'd1) begin
            bad++; $display("FAIL basic_cnt: got %0d want 1", irq_cnt);
        end
        tick();
        total++; if (irq !== !c_PULSE) begin
            bad++; $display("FAIL basic_cyc3: got irq=%b want %b", irq, !c_PULSE);
        end
    endtask

    task automatic test_id_tracking();
        status = 32'h0000_0110;
        tick();
        tick();
        total++; if (irq_id !== 5'd4 || irq !== !c_PULSE) begin
            bad++; $display("FAIL id_two_bits: got id=%0d irq=%b want id=4 irq=%b", irq_id, irq, !c_PULSE);
        end
        status = 32'h0000_0100;
        tick();
        tick();
        total++; if (irq_id !== 5'd8 || irq !== !c_PULSE || irq_cnt !== 16'd1) begin
            bad++; $display("FAIL id_move: got id=%0d irq=%b cnt=%0d want id=8 irq=%b cnt=1", irq_id, irq, irq_cnt, !c_PULSE);
        end
        holdoff = 16'd0;
        status  = 32'h0;
        tick();
        total++; if (irq !== !c_PULSE || irq_pend !== 1'b0) begin
            bad++; $display("FAIL clear_k1: got irq=%b pend=%b want irq=%b pend=0", irq, irq_pend, !c_PULSE);
        end
        tick();
        total++; if (irq !== 1'b0 || irq_id !== 5'd0) begin
            bad++; $display("FAIL clear_k2: got irq=%b id=%0d want irq=0 id=0", irq, irq_id);
        end
        tick();
        total++; if (irq !== 1'b0 || irq_cnt !== 16'd1) begin
            bad++; $display("FAIL clear_idle: got irq=%b cnt=%0d want irq=0 cnt=1", irq, irq_cnt);
        end
    endtask

    // Clear in cycle k, re-set in k+1: irq low k+2..k+7, high again at k+8.
    task automatic test_holdoff();
        logic exp;
        do_reset();
        mask    = 32'hFFFF_FFFF;
        holdoff = 16'd5;
        status  = 32'h0000_0001;
        tick();
        tick();
        total++; if (irq !== 1'b1 || irq_cnt !== 16'd1) begin
            bad++; $display("FAIL hold_first: got irq=%b cnt=%0d want irq=1 cnt=1", irq, irq_cnt);
        end
        status = 32'h0;
        tick();
        status = 32'h0000_0001;
        for (int j = 1; j <= 8; j++) begin
            if (j > 1) tick();
            if (j == 3) holdoff = 16'd0;
            if (j == 8)      exp = 1'b1;
            else if (j == 1) exp = !c_PULSE;
            else             exp = 1'b0;
            total++; if (irq !== exp) begin
                bad++; $display("FAIL hold_k%0d: got irq=%b want %b", j + 1, irq, exp);
            end
        end
        total++; if (irq_cnt !== 16'd2) begin
            bad++; $display("FAIL hold_cnt: got %0d want 2", irq_cnt);
        end
    endtask

    task automatic test_mask();
        status  = 32'h0;
        holdoff = 16'd0;
        tick();
        tick();
        tick();
        status = 32'h8000_0000;
        mask   = 32'h7FFF_FFFF;
        for (int j = 0; j < 4; j++) begin
            tick();
            total++; if (irq !== 1'b0 || irq_pend !== 1'b0) begin
                bad++; $display("FAIL mask_off_%0d: got irq=%b pend=%b want 0 0", j, irq, irq_pend);
            end
        end
        mask = 32'hFFFF_FFFF;
        tick();
        tick();
        total++; if (irq !== 1'b1 || irq_id !== 5'd31) begin
            bad++; $display("FAIL mask_on: got irq=%b id=%0d want irq=1 id=31", irq, irq_id);
        end
        mask = 32'h7FFF_FFFF;
        tick();
        tick();
        total++; if (irq !== 1'b0 || irq_pend !== 1'b0) begin
            bad++; $display("FAIL mask_remask: got irq=%b pend=%b want 0 0", irq, irq_pend);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        for (int i = 0; i < 17; i++) begin
            status2 = 32'h1;
            tick();
            tick();
            exp = (i >= 14) ? 4'hF : 4'(i + 1);
            total++; if (irq2 !== 1'b1 || irq_cnt2 !== exp) begin
                bad++; $display("FAIL sat_%0d: got irq=%b cnt=%0d want irq=1 cnt=%0d", i, irq2, irq_cnt2, exp);
            end
            status2 = 32'h0;
            tick();
            tick();
        end
    endtask

    task automatic test_reset_holdoff();
        mask    = 32'hFFFF_FFFF;
        holdoff = 16'd10;
        status  = 32'h0000_0004;
        tick();
        tick();
        status = 32'h0;
        tick();
        tick();
        total++; if (irq !== 1'b0) begin
            bad++; $display("FAIL rst_pre_holdoff: got irq=%b want 0", irq);
        end
        rst_n  = 1'b0;
        status = 32'h0000_0004;
        tick();
        total++; if ({irq, irq_id, irq_pend, irq_cnt} !== 23'd0) begin
            bad++; $display("FAIL rst_in_holdoff: got irq=%b id=%0d pend=%b cnt=%0d want all 0", irq, irq_id, irq_pend, irq_cnt);
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (irq !== 1'b1 || irq_id !== 5'd2 || irq_cnt !== 16'd1) begin
            bad++; $display("FAIL rst_no_residual: got irq=%b id=%0d cnt=%0d want irq=1 id=2 cnt=1", irq, irq_id, irq_cnt);
        end
    endtask

    task automatic test_hold_level();
        logic exp;
        status  = 32'h0;
        holdoff = 16'd0;
        tick();
        tick();
        tick();
        status = 32'h0000_0001;
        tick();
        for (int c = 2; c <= 5; c++) begin
            tick();
            exp = (c == 2) ? 1'b1 : !c_PULSE;
            total++; if (irq !== exp || irq_pend !== 1'b1) begin
                bad++; $display("FAIL level_cyc%0d: got irq=%b pend=%b want irq=%b pend=1", c, irq, irq_pend, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_id_tracking();
        test_holdoff();
        test_mask();
        test_saturation();
        test_reset_holdoff();
        test_hold_level();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
